// File: rtl/execution_sequencer_pkg.sv
// Shared definitions for the execution sequencer: opcodes, FSM states and
// program-counter control encoding. The decoder imports the same opcodes.
package seq_pkg;

  localparam int DEFAULT_PC_WIDTH = 8;

  localparam logic [3:0] OP_SETC  = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_CCOPY = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_NOT   = 4'h7;
  localparam logic [3:0] OP_SHL   = 4'h8;
  localparam logic [3:0] OP_SHR   = 4'h9;
  localparam logic [3:0] OP_LOAD  = 4'hA;
  localparam logic [3:0] OP_MOV   = 4'hB;
  localparam logic [3:0] OP_NOP   = 4'hC;
  localparam logic [3:0] OP_JMP   = 4'hD;
  localparam logic [3:0] OP_HALT  = 4'hE;
  localparam logic [3:0] OP_CHALT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_HALTED  = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_op_t;

endpackage

// File: rtl/execution_sequencer_if.sv
// Instruction-memory fetch port: request/address out, data/valid back.
interface execution_sequencer_if
  import seq_pkg::*;
#(
  parameter int PC_WIDTH = DEFAULT_PC_WIDTH
);

  logic                instrRequest;
  logic [PC_WIDTH-1:0] instructionAddress;
  logic [15:0]         instruction;
  logic                instrValid;

  modport master (
    output instrRequest,
    output instructionAddress,
    input  instruction,
    input  instrValid
  );

  modport slave (
    input  instrRequest,
    input  instructionAddress,
    output instruction,
    output instrValid
  );

endinterface

// File: rtl/execution_sequencer_program_counter.sv
// Program counter with hold / increment / load control. Arithmetic wraps
// modulo 2^PC_WIDTH.
module program_counter
  import seq_pkg::*;
#(
  parameter int                  PC_WIDTH = DEFAULT_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  pc_op_t              pcOp,
  input  logic [PC_WIDTH-1:0] loadValue,
  output logic [PC_WIDTH-1:0] pc
);

  // PC register: reset to RESET_PC, otherwise apply the requested operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else begin
      case (pcOp)
        PC_INC:  pc <= pc + PC_WIDTH'(1);
        PC_LOAD: pc <= loadValue;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/execution_sequencer.sv
// Multi-cycle control FSM: fetches each instruction with a valid handshake,
// holds it for the decoder, commits one register write per instruction and
// resolves jump / halt / conditional halt / conditional copy.
module execution_sequencer
  import seq_pkg::*;
#(
  parameter int                  PC_WIDTH = DEFAULT_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  execution_sequencer_if.master        mem,
  input  logic [7:0]                   condValue,
  input  logic                         runEnable,
  input  logic                         stepPulse,
  input  logic                         resumePulse,
  output logic [15:0]                  currentInstruction,
  output logic                         writeEnable,
  output logic                         halted,
  output logic [1:0]                   seqState
);

  seq_state_t          state;
  seq_state_t          nextState;
  pc_op_t              pcOp;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] jumpTarget;
  logic [3:0]          opcode;
  logic                condTrue;
  logic                irLoad;

  assign opcode     = currentInstruction[15:12];
  assign condTrue   = |condValue;
  assign jumpTarget = PC_WIDTH'(currentInstruction[7:0]);
  assign irLoad     = (state == ST_FETCH) && mem.instrValid;

  program_counter #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .pcOp      (pcOp),
    .loadValue (jumpTarget),
    .pc        (pc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Instruction register captures memory data on the accepting FETCH cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      currentInstruction <= 16'h0000;
    end else if (irLoad) begin
      currentInstruction <= mem.instruction;
    end
  end

  // Next-state, PC control and write-commit strobe.
  always_comb begin
    nextState   = state;
    pcOp        = PC_HOLD;
    writeEnable = 1'b0;
    case (state)
      ST_IDLE: begin
        if (runEnable || stepPulse) begin
          nextState = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem.instrValid) begin
          nextState = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        nextState = runEnable ? ST_FETCH : ST_IDLE;
        pcOp      = PC_INC;
        case (opcode)
          OP_CCOPY: writeEnable = condTrue;
          OP_NOP:   writeEnable = 1'b0;
          OP_JMP:   pcOp = PC_LOAD;
          OP_HALT: begin
            pcOp      = PC_HOLD;
            nextState = ST_HALTED;
          end
          OP_CHALT: begin
            if (condTrue) begin
              pcOp      = PC_HOLD;
              nextState = ST_HALTED;
            end
          end
          default:  writeEnable = 1'b1;
        endcase
      end
      ST_HALTED: begin
        if (resumePulse) begin
          pcOp      = PC_INC;
          nextState = runEnable ? ST_FETCH : ST_IDLE;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  assign mem.instrRequest       = (state == ST_FETCH);
  assign mem.instructionAddress = pc;
  assign halted                 = (state == ST_HALTED);
  assign seqState               = state;

endmodule

// File: tb/tb_execution_sequencer.sv
// Directed bench for execution_sequencer: a behavioural instruction memory
// with programmable wait states drives the fetch port; each task walks a
// short program cycle by cycle and compares a packed status snapshot.
module tb_execution_sequencer;

  logic        clk;
  logic        rst;
  logic [7:0]  condValue;
  logic        runEnable;
  logic        stepPulse;
  logic        resumePulse;
  logic [15:0] currentInstruction;
  logic        writeEnable;
  logic        halted;
  logic [1:0]  seqState;

  logic [15:0] memArr [256];
  int          waitCnt;
  int          waitCycles;
  int          checks;
  int          fails;
  int          weCount;
  logic [12:0] expv;

  execution_sequencer_if #(.PC_WIDTH(8)) mem ();

  execution_sequencer #(
    .PC_WIDTH (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .mem                (mem),
    .condValue          (condValue),
    .runEnable          (runEnable),
    .stepPulse          (stepPulse),
    .resumePulse        (resumePulse),
    .currentInstruction (currentInstruction),
    .writeEnable        (writeEnable),
    .halted             (halted),
    .seqState           (seqState)
  );

  assign mem.instruction = memArr[mem.instructionAddress];
  assign mem.instrValid  = mem.instrRequest && (waitCnt >= waitCycles);

  // Clock generator.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory latency counter: counts FETCH cycles spent waiting for data.
  always @(posedge clk or negedge rst) begin
    if (!rst) waitCnt <= 0;
    else if (mem.instrRequest && !mem.instrValid) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  function automatic logic [12:0] pack(input logic [1:0] st, input logic req,
                                       input logic we, input logic h, input logic [7:0] a);
    return {st, req, we, h, a};
  endfunction

  function automatic logic [12:0] snap();
    return {seqState, mem.instrRequest, writeEnable, halted, mem.instructionAddress};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) memArr[i] = 16'hE000;
  endtask

  task automatic doReset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clearMem();
    memArr[0] = 16'h0105;
    memArr[1] = 16'hE000;
    runEnable = 1'b1; waitCycles = 0; condValue = 8'h00;
    rst = 1'b0;
    tick();
    expv = pack(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL reset_outputs: got %h expected %h", snap(), expv); end
    checks++; if (currentInstruction !== 16'h0000) begin fails++; $display("[TB] FAIL reset_ir: got %h expected 0000", currentInstruction); end
    rst = 1'b1;
    tick();
    expv = pack(2'd1, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL first_fetch: got %h expected %h", snap(), expv); end
    tick();
    expv = pack(2'd2, 1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL first_execute: got %h expected %h", snap(), expv); end
    checks++; if (currentInstruction !== 16'h0105) begin fails++; $display("[TB] FAIL first_ir: got %h expected 0105", currentInstruction); end
    tick();
    expv = pack(2'd1, 1'b1, 1'b0, 1'b0, 8'h01);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL pc_after_first: got %h expected %h", snap(), expv); end
    tick();
    tick();
    expv = pack(2'd3, 1'b0, 1'b0, 1'b1, 8'h01);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL halt_after_first: got %h expected %h", snap(), expv); end
  endtask

  task automatic test_wait_states();
    clearMem();
    memArr[0] = 16'hD004;
    memArr[4] = 16'h1234;
    runEnable = 1'b1; waitCycles = 0;
    doReset();
    tick();
    tick();
    expv = pack(2'd2, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL wait_jump_exec: got %h expected %h", snap(), expv); end
    waitCycles = 3;
    weCount = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      weCount += int'(writeEnable);
      expv = pack(2'd1, 1'b1, 1'b0, 1'b0, 8'h04);
      checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL wait_fetch_%0d: got %h expected %h", i, snap(), expv); end
      if (i == 1) runEnable = 1'b0;
    end
    tick();
    weCount += int'(writeEnable);
    expv = pack(2'd2, 1'b0, 1'b1, 1'b0, 8'h04);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL wait_execute: got %h expected %h", snap(), expv); end
    waitCycles = 0;
    tick();
    weCount += int'(writeEnable);
    expv = pack(2'd0, 1'b0, 1'b0, 1'b0, 8'h05);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL run_drop_idle: got %h expected %h", snap(), expv); end
    tick();
    weCount += int'(writeEnable);
    expv = pack(2'd0, 1'b0, 1'b0, 1'b0, 8'h05);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL idle_stays: got %h expected %h", snap(), expv); end
    checks++; if (weCount !== 1) begin fails++; $display("[TB] FAIL wait_we_pulses: got %0d expected 1", weCount); end
  endtask

  task automatic test_jump_wrap();
    clearMem();
    memArr[0]     = 16'hD0FF;
    memArr[8'hFF] = 16'h1ABC;
    runEnable = 1'b1; waitCycles = 0;
    doReset();
    tick();
    tick();
    tick();
    expv = pack(2'd1, 1'b1, 1'b0, 1'b0, 8'hFF);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL jump_ff: got %h expected %h", snap(), expv); end
    tick();
    expv = pack(2'd2, 1'b0, 1'b1, 1'b0, 8'hFF);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL add_at_ff: got %h expected %h", snap(), expv); end
    runEnable = 1'b0;
    tick();
    expv = pack(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL pc_wrap: got %h expected %h", snap(), expv); end

    clearMem();
    memArr[0] = 16'hD002;
    memArr[2] = 16'hD010;
    runEnable = 1'b1;
    doReset();
    tick();
    tick();
    tick();
    expv = pack(2'd1, 1'b1, 1'b0, 1'b0, 8'h02);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL jump_2: got %h expected %h", snap(), expv); end
    tick();
    expv = pack(2'd2, 1'b0, 1'b0, 1'b0, 8'h02);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL jump_no_write: got %h expected %h", snap(), expv); end
    checks++; if (currentInstruction !== 16'hD010) begin fails++; $display("[TB] FAIL jump_ir: got %h expected D010", currentInstruction); end
    tick();
    expv = pack(2'd1, 1'b1, 1'b0, 1'b0, 8'h10);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL jump_target: got %h expected %h", snap(), expv); end
  endtask

  task automatic test_conditional();
    clearMem();
    memArr[0] = 16'h3123;
    memArr[1] = 16'h3123;
    memArr[2] = 16'hF003;
    memArr[3] = 16'hF003;
    memArr[4] = 16'hE000;
    runEnable = 1'b1; waitCycles = 0; condValue = 8'h00;
    doReset();
    tick();
    tick();
    expv = pack(2'd2, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL ccopy_false: got %h expected %h", snap(), expv); end
    tick();
    expv = pack(2'd1, 1'b1, 1'b0, 1'b0, 8'h01);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL ccopy_false_pc: got %h expected %h", snap(), expv); end
    condValue = 8'h01;
    tick();
    expv = pack(2'd2, 1'b0, 1'b1, 1'b0, 8'h01);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL ccopy_true: got %h expected %h", snap(), expv); end
    tick();
    condValue = 8'h05;
    tick();
    expv = pack(2'd2, 1'b0, 1'b0, 1'b0, 8'h02);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL chalt_true_exec: got %h expected %h", snap(), expv); end
    tick();
    expv = pack(2'd3, 1'b0, 1'b0, 1'b1, 8'h02);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL chalt_true_halted: got %h expected %h", snap(), expv); end
    condValue = 8'h00;
    resumePulse = 1'b1;
    tick();
    resumePulse = 1'b0;
    expv = pack(2'd1, 1'b1, 1'b0, 1'b0, 8'h03);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL resume_run: got %h expected %h", snap(), expv); end
    tick();
    expv = pack(2'd2, 1'b0, 1'b0, 1'b0, 8'h03);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL chalt_false_exec: got %h expected %h", snap(), expv); end
    tick();
    expv = pack(2'd1, 1'b1, 1'b0, 1'b0, 8'h04);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL chalt_false_pc: got %h expected %h", snap(), expv); end
  endtask

  task automatic test_halt_resume_step();
    clearMem();
    memArr[0] = 16'hD006;
    memArr[6] = 16'hE000;
    memArr[7] = 16'h0042;
    runEnable = 1'b1; waitCycles = 0; condValue = 8'h00;
    doReset();
    tick();
    tick();
    tick();
    runEnable = 1'b0;
    tick();
    expv = pack(2'd2, 1'b0, 1'b0, 1'b0, 8'h06);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL halt_exec: got %h expected %h", snap(), expv); end
    tick();
    expv = pack(2'd3, 1'b0, 1'b0, 1'b1, 8'h06);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL halt_state: got %h expected %h", snap(), expv); end
    stepPulse = 1'b1; runEnable = 1'b1;
    tick();
    stepPulse = 1'b0; runEnable = 1'b0;
    expv = pack(2'd3, 1'b0, 1'b0, 1'b1, 8'h06);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL halt_ignores_step: got %h expected %h", snap(), expv); end
    resumePulse = 1'b1;
    tick();
    resumePulse = 1'b0;
    expv = pack(2'd0, 1'b0, 1'b0, 1'b0, 8'h07);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL resume_idle: got %h expected %h", snap(), expv); end
    tick();
    expv = pack(2'd0, 1'b0, 1'b0, 1'b0, 8'h07);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL idle_waits: got %h expected %h", snap(), expv); end
    stepPulse = 1'b1;
    tick();
    stepPulse = 1'b0;
    expv = pack(2'd1, 1'b1, 1'b0, 1'b0, 8'h07);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL step_fetch: got %h expected %h", snap(), expv); end
    tick();
    expv = pack(2'd2, 1'b0, 1'b1, 1'b0, 8'h07);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL step_exec: got %h expected %h", snap(), expv); end
    tick();
    expv = pack(2'd0, 1'b0, 1'b0, 1'b0, 8'h08);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL step_back_idle: got %h expected %h", snap(), expv); end
    tick();
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL step_single: got %h expected %h", snap(), expv); end
  endtask

  task automatic test_reset_mid();
    clearMem();
    memArr[0] = 16'hD005;
    memArr[5] = 16'hE000;
    runEnable = 1'b1; waitCycles = 2; condValue = 8'h00;
    doReset();
    tick();
    tick();
    expv = pack(2'd1, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL mid_fetch_wait: got %h expected %h", snap(), expv); end
    rst = 1'b0;
    #1;
    expv = pack(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL reset_in_fetch: got %h expected %h", snap(), expv); end
    checks++; if (currentInstruction !== 16'h0000) begin fails++; $display("[TB] FAIL reset_in_fetch_ir: got %h expected 0000", currentInstruction); end
    waitCycles = 0;
    tick();
    doReset();
    for (int i = 0; i < 5; i++) tick();
    expv = pack(2'd3, 1'b0, 1'b0, 1'b1, 8'h05);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL pre_reset_halted: got %h expected %h", snap(), expv); end
    rst = 1'b0;
    #1;
    expv = pack(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (snap() !== expv) begin fails++; $display("[TB] FAIL reset_in_halted: got %h expected %h", snap(), expv); end
    checks++; if (currentInstruction !== 16'h0000) begin fails++; $display("[TB] FAIL reset_in_halted_ir: got %h expected 0000", currentInstruction); end
    tick();
    rst = 1'b1;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    checks = 0; fails = 0; weCount = 0;
    rst = 1'b0; runEnable = 1'b0; stepPulse = 1'b0; resumePulse = 1'b0;
    condValue = 8'h00; waitCycles = 0;
    clearMem();
    test_reset();
    test_wait_states();
    test_jump_wrap();
    test_conditional();
    test_halt_resume_step();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/execution_sequencer.md
# execution_sequencer

Multi-cycle control FSM that sequences the processor datapath. It owns the program counter, fetches each 16-bit instruction from instruction memory with a valid handshake, and holds it in an instruction register for the combinational decoder. It commits one register write per instruction and resolves jump, unconditional halt and conditional halt/copy against live register data. It sits between instruction memory and the decoder/datapath, replacing the free-running PC increment with run, single-step and resume control.

## Interface
- PC_WIDTH, 8, program counter and instruction-address width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- instruction  in  16  instruction-memory read data
- instrValid  in  1  memory data valid; sampled only while instrRequest=1
- condValue  in  8  datapath read port value of register IR[3:0], combinational from currentInstruction
- runEnable  in  1  level; 1 = free run, 0 = single-step
- stepPulse  in  1  one-cycle pulse; executes one instruction from IDLE
- resumePulse  in  1  one-cycle pulse; leaves HALTED
- instrRequest  out  1  fetch request to instruction memory
- instructionAddress  out  PC_WIDTH  program counter
- currentInstruction  out  16  instruction register, drives the decoder
- writeEnable  out  1  register-file write commit strobe
- halted  out  1  1 while in HALTED
- seqState  out  2  state encoding, for debug LEDs

## Operation
- States: IDLE=0, FETCH=1, EXECUTE=2, HALTED=3.
- **IDLE:**
  - runEnable=1 or stepPulse=1 → FETCH.
  - runEnable dominates when both are asserted.
- **FETCH:**
  - instrRequest=1; instructionAddress is held stable.
  - On instrValid=1: IR ← instruction, → EXECUTE.
  - Otherwise wait indefinitely.
- **EXECUTE:** one cycle; decodes IR[15:12].
  - 0000–1011 except 0011: writeEnable=1, PC ← PC+1.
  - 0011 (conditional copy): writeEnable = (condValue≠0), PC ← PC+1.
  - 1100 (unused): NOP, PC ← PC+1.
  - 1101 (jump): PC ← IR[7:0], no write.
  - 1110 (halt): PC unchanged, no write → HALTED.
  - 1111 (conditional halt): if condValue≠0, PC unchanged, no write → HALTED. Otherwise PC ← PC+1.
  - Non-halt exit: → FETCH if runEnable=1, else → IDLE.
- **HALTED:**
  - halted=1.
  - resumePulse: PC ← PC+1, then → FETCH if runEnable=1, else → IDLE.
  - stepPulse and runEnable are ignored.
- writeEnable is asserted only in EXECUTE, never in any other state.
- PC arithmetic is modulo 2^PC_WIDTH: 8'hFF+1 = 8'h00. A jump to its own address loops legally.

## Timing
- **Reset (async, rst=0):**
  - state=IDLE, instructionAddress=RESET_PC, currentInstruction=16'h0000.
  - instrRequest=0, writeEnable=0, halted=0.
  - Reset takes effect immediately in any state, including mid-FETCH; a pending memory response is discarded.
- Outputs other than writeEnable are registered. writeEnable is a Moore/Mealy output of EXECUTE and IR/condValue.
- Minimum instruction latency is 2 cycles (FETCH with instrValid in the same cycle, then EXECUTE). Each extra wait cycle of instrValid adds one.
- The new PC is visible on the cycle after EXECUTE. The register write happens at the rising edge that ends EXECUTE.
- condValue must settle within the EXECUTE cycle (combinational register-file read).
- instrValid outside FETCH is ignored.
- Free run throughput is one instruction per 2 cycles at zero memory latency.
- Deasserting runEnable mid-FETCH completes the current instruction, then returns to IDLE.

## Structure
- Shared package `seq_pkg`:
  - opcode constants OP_SETC..OP_CHALT (4 bits, 0000–1111);
  - state enum `seq_state_t` (2 bits);
  - PC_WIDTH default.
- The decoder imports the same opcode constants.
- One sub-module, `program_counter`: holds the PC with hold/increment/load controls and RESET_PC. The FSM drives its controls.
- The FSM, instruction register and writeEnable logic live in the top module.

## Test plan
- Reset and fetch: release rst with runEnable=1, memory latency 0, mem[0]=16'h0105 → FETCH at cycle 1, writeEnable=1 in cycle 2, instructionAddress=1 in cycle 3.
- Memory wait states: instrValid delayed 3 cycles at address 4 → instrRequest=1 and address=4 held for 4 cycles, exactly one writeEnable pulse.
- Jump and wrap:
  - mem[8'hFF]=ADD → next PC=8'h00.
  - mem[2]=16'hD010 → next PC=8'h10, no writeEnable.
- Conditional paths:
  - 16'h3123 with condValue=0 → writeEnable=0, PC+1.
  - Same instruction with condValue=8'h01 → writeEnable=1.
  - 16'hF003 with condValue=5 → HALTED, PC unchanged.
  - 16'hF003 with condValue=0 → PC+1.
- Halt, resume and step:
  - 16'hE000 at PC=6 → halted=1, stepPulse ignored.
  - resumePulse with runEnable=0 → IDLE, PC=7.
  - stepPulse → exactly one instruction, back to IDLE.
- Reset mid-operation: assert rst in FETCH and in HALTED → all outputs return to reset values in the same cycle, with no writeEnable glitch.
